mips_instr_encoder: RTL



---
 rtl/mips_instr_encoder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mips_instr_encoder.sv
// Symbolic-instruction encoder and sequential loader for the single-cycle MIPS instruction memory.
// Optional macro ENC_ILLEGAL_TRAP_EN: mnemonic 31 is dropped and flags err instead of writing a nop.
module mips_instr_encoder #(
   parameter int AW    = 8,
   parameter int DEPTH = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          restart,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    mnem,
   input  logic [4:0]    rs,
   input  logic [4:0]    rt,
   input  logic [4:0]    rd,
   input  logic [4:0]    shamt,
   input  logic [15:0]   imm,
   input  logic [25:0]   target,
   output logic          mem_valid,
   input  logic          mem_ready,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [AW:0]   words,
   output logic          full,
   output logic          err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   localparam logic [1:0] K_R = 2'd0;
   localparam logic [1:0] K_I = 2'd1;
   localparam logic [1:0] K_J = 2'd2;
   localparam logic [1:0] K_Z = 2'd3;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [1:0] state;
   logic       pend;
   logic       err_r;
   logic       illegal;

`ifdef ENC_ILLEGAL_TRAP_EN
   assign illegal = (mnem == 5'd31);
`else
   assign illegal = 1'b0;
`endif

   function automatic logic [31:0] encode(
      input logic [4:0]  m,
      input logic [4:0]  f_rs,
      input logic [4:0]  f_rt,
      input logic [4:0]  f_rd,
      input logic [4:0]  f_sh,
      input logic [15:0] f_imm,
      input logic [25:0] f_tgt
   );
      logic [1:0] kind;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] s;
      logic [4:0] t;
      logic [4:0] d;
      logic [4:0] sh;
      kind = K_R;
      op   = 6'd0;
      fn   = 6'd0;
      s    = f_rs;
      t    = f_rt;
      d    = f_rd;
      sh   = 5'd0;
      case (m)
         5'd0:  fn = 6'b100000;
         5'd1:  fn = 6'b100001;
         5'd2:  fn = 6'b100010;
         5'd3:  fn = 6'b100011;
         5'd4:  fn = 6'b100100;
         5'd5:  fn = 6'b100101;
         5'd6:  fn = 6'b100110;
         5'd7:  fn = 6'b100111;
         5'd8:  fn = 6'b101010;
         5'd9:  fn = 6'b101011;
         // constant shifts carry shamt and never use rs
         5'd10: begin fn = 6'b000000; s = 5'd0; sh = f_sh; end
         5'd11: begin fn = 6'b000010; s = 5'd0; sh = f_sh; end
         5'd12: begin fn = 6'b000011; s = 5'd0; sh = f_sh; end
         5'd13: fn = 6'b000100;
         5'd14: fn = 6'b000110;
         5'd15: fn = 6'b000111;
         5'd16: begin fn = 6'b001000; t = 5'd0; d = 5'd0; end
         5'd17: begin kind = K_I; op = 6'b001000; end
         5'd18: begin kind = K_I; op = 6'b001001; end
         5'd19: begin kind = K_I; op = 6'b001100; end
         5'd20: begin kind = K_I; op = 6'b001101; end
         5'd21: begin kind = K_I; op = 6'b001110; end
         5'd22: begin kind = K_I; op = 6'b100011; end
         5'd23: begin kind = K_I; op = 6'b101011; end
         5'd24: begin kind = K_I; op = 6'b000100; end
         5'd25: begin kind = K_I; op = 6'b000101; end
         5'd26: begin kind = K_I; op = 6'b001111; s = 5'd0; end
         5'd27: begin kind = K_J; op = 6'b000010; end
         5'd28: begin kind = K_J; op = 6'b000011; end
         5'd29: begin kind = K_I; op = 6'b001010; end
         5'd30: begin kind = K_I; op = 6'b001011; end
         default: kind = K_Z;
      endcase
      case (kind)
         K_R:     encode = {6'd0, s, t, d, sh, fn};
         K_I:     encode = {op, s, t, f_imm};
         K_J:     encode = {op, f_tgt};
         default: encode = 32'h0000_0000;
      endcase
   endfunction

   assign in_ready  = (state == S_IDLE);
   assign mem_valid = (state == S_WRITE);
   assign full      = (state == S_FULL);
   assign err       = err_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pend      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         words     <= '0;
         err_r     <= 1'b0;
      end else begin
         case (state)
            S_WRITE: begin
               if (restart)
                  pend <= 1'b1;
               if (mem_ready) begin
                  // a restart seen during the write takes effect once the word lands
                  if (pend || restart) begin
                     mem_addr <= '0;
                     words    <= '0;
                     err_r    <= 1'b0;
                     pend     <= 1'b0;
                     state    <= S_IDLE;
                  end else begin
                     mem_addr <= mem_addr + 1'b1;
                     words    <= words + 1'b1;
                     state    <= (words + 1'b1 == DEPTH_W) ? S_FULL : S_IDLE;
                  end
               end
            end
            S_FULL: begin
               if (restart) begin
                  mem_addr <= '0;
                  words    <= '0;
                  err_r    <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: begin
               if (restart) begin
                  mem_addr <= '0;
                  words    <= '0;
                  err_r    <= 1'b0;
               end
               if (in_valid) begin
                  if (illegal)
                     err_r <= 1'b1;
                  else begin
                     mem_wdata <= encode(mnem, rs, rt, rd, shamt, imm, target);
                     state     <= S_WRITE;
                  end
               end
            end
         endcase
      end
   end

endmodule
